sram_arbiter: RTL



---
 rtl/sram_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 55 +++++
 rtl/sram_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared types for the external SRAM arbiter: bus widths, write-FSM states
// and the write-buffer entry layout.
package sram_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETUP   = 2'd1,
        S_PULSE   = 2'd2,
        S_RECOVER = 2'd3
    } sram_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } sram_wr_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through output; pointers carry one
// extra wrap bit so full and empty can be told apart without a counter.
module sync_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTR_W = IDX_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (wr_ptr_r[PTR_W-1] != rd_ptr_r[PTR_W-1]) &&
                       (wr_ptr_r[IDX_W-1:0] == rd_ptr_r[IDX_W-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign dout      = mem_r[rd_ptr_r[IDX_W-1:0]];

    // Pointer update; pushes into a full FIFO are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[IDX_W-1:0]] <= din;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Sole owner of the external SRAM bus: display reads have priority, buffered
// loader writes drain through a setup/pulse/recover FSM while reads are idle.
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int WFIFO_DEPTH = 4,
    parameter int WR_CYCLES   = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_busy,
    output logic              o_rd_conflict,
    output logic [ADDR_W-1:0] o_sram_addr,
    inout  wire  [DATA_W-1:0] io_sram_dq,
    output logic              o_sram_we_n,
    output logic              o_sram_oe_n,
    output logic              o_sram_ce_n,
    output logic              o_sram_lb_n,
    output logic              o_sram_ub_n
);

    localparam int CNT_W = $clog2(WR_CYCLES + 1);

    sram_state_t       state_r;
    sram_state_t       state_next_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_next_s;
    sram_wr_t          wr_q_r;
    sram_wr_t          fifo_din_s;
    sram_wr_t          fifo_dout_s;
    logic              fifo_pop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              bus_drive_s;
    logic [DATA_W-1:0] rd_data_r;
    logic              rd_valid_r;
    logic              rd_conflict_r;

    assign fifo_din_s = '{addr: i_wr_addr, data: i_wr_data};

    sync_fifo #(
        .WIDTH ($bits(sram_wr_t)),
        .DEPTH (WFIFO_DEPTH)
    ) u_wfifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (i_wr_valid),
        .pop   (fifo_pop_s),
        .din   (fifo_din_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Write FSM next state; a pending read always blocks a new write from starting.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        fifo_pop_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (!fifo_empty_s && !i_rd_en) begin
                    state_next_s = S_SETUP;
                    fifo_pop_s   = 1'b1;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_SETUP: begin
                state_next_s = S_PULSE;
                cnt_next_s   = {CNT_W{1'b0}};
            end
            S_PULSE: begin
                if (cnt_r == CNT_W'(WR_CYCLES - 1)) begin
                    state_next_s = S_RECOVER;
                end else begin
                    cnt_next_s = cnt_r + CNT_W'(1);
                end
            end
            S_RECOVER: state_next_s = S_IDLE;
            default:   state_next_s = S_IDLE;
        endcase
    end

    // FSM state, pulse counter and the latched write being performed.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r <= S_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            wr_q_r  <= '{addr: {ADDR_W{1'b0}}, data: {DATA_W{1'b0}}};
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            if (fifo_pop_s) begin
                wr_q_r <= fifo_dout_s;
            end
        end
    end

    // Read capture and conflict flag; read data holds while a write owns the bus.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rd_data_r     <= {DATA_W{1'b0}};
            rd_valid_r    <= 1'b0;
            rd_conflict_r <= 1'b0;
        end else if (state_r == S_IDLE) begin
            rd_data_r     <= io_sram_dq;
            rd_valid_r    <= i_rd_en;
            rd_conflict_r <= 1'b0;
        end else begin
            rd_valid_r    <= 1'b0;
            rd_conflict_r <= i_rd_en;
        end
    end

    assign bus_drive_s   = (state_r != S_IDLE);
    assign o_sram_addr   = bus_drive_s ? wr_q_r.addr : i_rd_addr;
    assign io_sram_dq    = bus_drive_s ? wr_q_r.data : {DATA_W{1'bz}};
    assign o_sram_oe_n   = bus_drive_s;
    assign o_sram_we_n   = (state_r != S_PULSE);
    assign o_sram_ce_n   = 1'b0;
    assign o_sram_lb_n   = 1'b0;
    assign o_sram_ub_n   = 1'b0;
    assign o_wr_ready    = !fifo_full_s;
    assign o_wr_busy     = !fifo_empty_s || bus_drive_s;
    assign o_rd_data     = rd_data_r;
    assign o_rd_valid    = rd_valid_r;
    assign o_rd_conflict = rd_conflict_r;

endmodule
